// File: rtl/mailbox_pkg.sv
// Shared types and widths for the mailbox APB bridge.
package mailbox_pkg;

  localparam int unsigned AddrWidth = 6;
  localparam int unsigned DataWidth = 32;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAccess  = 2'd1,
    StRecover = 2'd2
  } bridge_state_e;

endpackage

// File: rtl/mailbox_apb_bridge_if.sv
// APB slave port plus the downstream mailbox-controller port of one bridge instance.
interface mailbox_apb_bridge_if;
  import mailbox_pkg::*;

  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [AddrWidth-1:0] paddr;
  logic [DataWidth-1:0] pwdata;
  logic                 pready;
  logic [DataWidth-1:0] prdata;
  logic                 pslverr;

  logic                 mbx_write;
  logic                 mbx_read;
  logic [AddrWidth-1:0] mbx_addr;
  logic [DataWidth-1:0] mbx_wdata;
  logic                 mbx_ready;
  logic [DataWidth-1:0] mbx_rdata;

  // Bridge side.
  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, mbx_ready, mbx_rdata,
    output pready, prdata, pslverr, mbx_write, mbx_read, mbx_addr, mbx_wdata
  );

  // APB master and mailbox controller side.
  modport master (
    output psel, penable, pwrite, paddr, pwdata, mbx_ready, mbx_rdata,
    input  pready, prdata, pslverr, mbx_write, mbx_read, mbx_addr, mbx_wdata
  );

endinterface

// File: rtl/mailbox_apb_bridge.sv
// APB-to-mailbox bridge: forwards one APB transfer at a time to the mailbox controller,
// with a bounded wait and a registered single-cycle pready pulse.
module mailbox_apb_bridge
  import mailbox_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                clk,
  input logic                resetn,
  mailbox_apb_bridge_if.slave bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  bridge_state_e        state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 pready_q, pready_d;
  logic [DataWidth-1:0] prdata_q, prdata_d;
  logic                 pslverr_q, pslverr_d;
  logic                 write_q, write_d;
  logic                 read_q, read_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = 1'b0;
    prdata_d  = '0;
    pslverr_d = 1'b0;
    write_d   = write_q;
    read_d    = read_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (bus.psel && bus.penable) begin
          if (bus.paddr[1:0] == 2'b00) begin
            addr_d  = bus.paddr;
            wdata_d = bus.pwdata;
            write_d = bus.pwrite;
            read_d  = !bus.pwrite;
            cnt_d   = '0;
            state_d = StAccess;
          end else begin
            // Misaligned: answer with an error without touching the controller.
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            state_d   = StRecover;
          end
        end
      end

      StAccess: begin
        // Completion wins over a timeout landing in the same cycle.
        if (bus.mbx_ready) begin
          write_d  = 1'b0;
          read_d   = 1'b0;
          pready_d = 1'b1;
          prdata_d = read_q ? bus.mbx_rdata : '0;
          state_d  = StRecover;
        end else if (cnt_q == CntMax) begin
          write_d   = 1'b0;
          read_d    = 1'b0;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          state_d   = StRecover;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StRecover: begin
        // Wait for the controller to release mbx_ready before taking new work.
        if (!bus.mbx_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      write_q   <= write_d;
      read_q    <= read_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus.pready    = pready_q;
  assign bus.prdata    = prdata_q;
  assign bus.pslverr   = pslverr_q;
  assign bus.mbx_write = write_q;
  assign bus.mbx_read  = read_q;
  assign bus.mbx_addr  = addr_q;
  assign bus.mbx_wdata = wdata_q;

endmodule

// File: tb/tb_mailbox_apb_bridge.sv
// Directed bench for mailbox_apb_bridge: latency, wait states, timeout, misalignment,
// mid-transfer reset and RECOVER back-pressure.
module tb_mailbox_apb_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic        held;

  mailbox_apb_bridge_if bus ();

  mailbox_apb_bridge #(
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Setup phase for one cycle, then leaves the access phase driven (cycle 0).
  task automatic apb_start(input logic wr, input logic [5:0] addr, input logic [31:0] data);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = data;
    step();
    bus.penable = 1'b1;
  endtask

  task automatic apb_end();
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.psel      = 1'b0;
    bus.penable   = 1'b0;
    bus.pwrite    = 1'b0;
    bus.paddr     = '0;
    bus.pwdata    = '0;
    bus.mbx_ready = 1'b0;
    bus.mbx_rdata = '0;

    // Reset state
    step();
    step();
    chk("rst_pready",    32'(bus.pready),    32'd0);
    chk("rst_prdata",    bus.prdata,         32'd0);
    chk("rst_pslverr",   32'(bus.pslverr),   32'd0);
    chk("rst_mbx_write", 32'(bus.mbx_write), 32'd0);
    chk("rst_mbx_read",  32'(bus.mbx_read),  32'd0);
    chk("rst_mbx_addr",  32'(bus.mbx_addr),  32'd0);
    chk("rst_mbx_wdata", bus.mbx_wdata,      32'd0);
    resetn = 1'b1;
    step();

    // Read 0x00, ready in cycle 2, pready in cycle 3
    apb_start(1'b0, 6'h00, 32'h0);
    chk("rd0_c0_strobe", 32'(bus.mbx_read), 32'd0);
    step();
    chk("rd0_c1_read",   32'(bus.mbx_read),  32'd1);
    chk("rd0_c1_write",  32'(bus.mbx_write), 32'd0);
    chk("rd0_c1_pready", 32'(bus.pready),    32'd0);
    step();
    bus.mbx_ready = 1'b1;
    bus.mbx_rdata = 32'h0000_0001;
    chk("rd0_c2_pready", 32'(bus.pready), 32'd0);
    step();
    chk("rd0_c3_pready",  32'(bus.pready),   32'd1);
    chk("rd0_c3_prdata",  bus.prdata,        32'h0000_0001);
    chk("rd0_c3_pslverr", 32'(bus.pslverr),  32'd0);
    chk("rd0_c3_read",    32'(bus.mbx_read), 32'd0);
    bus.mbx_ready = 1'b0;
    bus.mbx_rdata = '0;
    apb_end();
    step();
    chk("rd0_c4_pready", 32'(bus.pready), 32'd0);
    chk("rd0_c4_prdata", bus.prdata,      32'd0);

    // Write 0x30 with five strobe cycles
    apb_start(1'b1, 6'h30, 32'hDEAD_BEEF);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("wr30_write",  32'(bus.mbx_write), 32'd1);
      chk("wr30_read",   32'(bus.mbx_read),  32'd0);
      chk("wr30_addr",   32'(bus.mbx_addr),  32'h30);
      chk("wr30_wdata",  bus.mbx_wdata,      32'hDEAD_BEEF);
      chk("wr30_pready", 32'(bus.pready),    32'd0);
      if (i == 5) bus.mbx_ready = 1'b1;
    end
    bus.mbx_rdata = 32'h1234_5678;
    step();
    chk("wr30_done_pready",  32'(bus.pready),    32'd1);
    chk("wr30_done_pslverr", 32'(bus.pslverr),   32'd0);
    chk("wr30_done_prdata",  bus.prdata,         32'd0);
    chk("wr30_done_write",   32'(bus.mbx_write), 32'd0);
    bus.mbx_ready = 1'b0;
    apb_end();
    step();
    chk("wr30_after_pready", 32'(bus.pready), 32'd0);

    // Read 0x10 timeout; psel dropped during ACCESS
    bus.mbx_rdata = 32'hFFFF_FFFF;
    apb_start(1'b0, 6'h10, 32'h0);
    step();
    chk("to_c1_read", 32'(bus.mbx_read), 32'd1);
    chk("to_c1_addr", 32'(bus.mbx_addr), 32'h10);
    apb_end();
    held = 1'b1;
    for (int i = 2; i <= 64; i++) begin
      step();
      if (bus.mbx_read !== 1'b1 || bus.pready !== 1'b0) held = 1'b0;
    end
    chk("to_strobe_held_64", 32'(held), 32'd1);
    step();
    chk("to_pready",  32'(bus.pready),   32'd1);
    chk("to_pslverr", 32'(bus.pslverr),  32'd1);
    chk("to_prdata",  bus.prdata,        32'd0);
    chk("to_read",    32'(bus.mbx_read), 32'd0);
    step();
    chk("to_after_pready",  32'(bus.pready),  32'd0);
    chk("to_after_pslverr", 32'(bus.pslverr), 32'd0);

    // Misaligned read 0x22
    apb_start(1'b0, 6'h22, 32'h0);
    step();
    chk("mis_pready",  32'(bus.pready),    32'd1);
    chk("mis_pslverr", 32'(bus.pslverr),   32'd1);
    chk("mis_prdata",  bus.prdata,         32'd0);
    chk("mis_read",    32'(bus.mbx_read),  32'd0);
    chk("mis_write",   32'(bus.mbx_write), 32'd0);
    apb_end();
    step();
    chk("mis_after_pready", 32'(bus.pready),   32'd0);
    chk("mis_after_read",   32'(bus.mbx_read), 32'd0);

    // Ready arrives in the very cycle the counter hits its limit
    bus.mbx_rdata = 32'hCAFE_0001;
    apb_start(1'b0, 6'h04, 32'h0);
    held = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (bus.mbx_read !== 1'b1 || bus.pready !== 1'b0) held = 1'b0;
      if (i == 64) bus.mbx_ready = 1'b1;
    end
    chk("edge_held", 32'(held), 32'd1);
    step();
    chk("edge_pready",  32'(bus.pready),   32'd1);
    chk("edge_pslverr", 32'(bus.pslverr),  32'd0);
    chk("edge_prdata",  bus.prdata,        32'hCAFE_0001);
    chk("edge_read",    32'(bus.mbx_read), 32'd0);
    bus.mbx_ready = 1'b0;
    bus.mbx_rdata = '0;
    apb_end();
    step();

    // Reset two cycles into ACCESS
    apb_start(1'b1, 6'h08, 32'hA5A5_5A5A);
    step();
    step();
    chk("ab_pre_write", 32'(bus.mbx_write), 32'd1);
    resetn = 1'b0;
    #1;
    chk("ab_rst_write", 32'(bus.mbx_write), 32'd0);
    chk("ab_rst_addr",  32'(bus.mbx_addr),  32'd0);
    chk("ab_rst_wdata", bus.mbx_wdata,      32'd0);
    apb_end();
    step();
    resetn = 1'b1;
    held = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.pready !== 1'b0 || bus.mbx_write !== 1'b0) held = 1'b0;
    end
    chk("ab_no_pready", 32'(held), 32'd1);

    // Back-to-back writes; controller holds mbx_ready late
    apb_start(1'b1, 6'h0C, 32'h1111_1111);
    step();
    chk("bb1_write", 32'(bus.mbx_write), 32'd1);
    chk("bb1_wdata", bus.mbx_wdata,      32'h1111_1111);
    step();
    bus.mbx_ready = 1'b1;
    step();
    chk("bb1_pready", 32'(bus.pready),    32'd1);
    chk("bb1_done",   32'(bus.mbx_write), 32'd0);
    apb_end();
    step();
    chk("bb_c4_pready", 32'(bus.pready), 32'd0);
    apb_start(1'b1, 6'h14, 32'h2222_2222);
    chk("bb_c5_write", 32'(bus.mbx_write), 32'd0);
    step();
    chk("bb_c6_write",  32'(bus.mbx_write), 32'd0);
    chk("bb_c6_pready", 32'(bus.pready),    32'd0);
    bus.mbx_ready = 1'b0;
    step();
    chk("bb_c7_write", 32'(bus.mbx_write), 32'd0);
    step();
    chk("bb2_write", 32'(bus.mbx_write), 32'd1);
    chk("bb2_addr",  32'(bus.mbx_addr),  32'h14);
    chk("bb2_wdata", bus.mbx_wdata,      32'h2222_2222);
    step();
    bus.mbx_ready = 1'b1;
    step();
    chk("bb2_pready",  32'(bus.pready),    32'd1);
    chk("bb2_pslverr", 32'(bus.pslverr),   32'd0);
    chk("bb2_done",    32'(bus.mbx_write), 32'd0);
    bus.mbx_ready = 1'b0;
    apb_end();
    step();
    chk("bb2_after_pready", 32'(bus.pready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mailbox_apb_bridge.md
MAILBOX_APB_BRIDGE -- requirements
Module: mailbox_apb_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum ACCESS-state cycles before an error response; legal range 4..1023.
REQ-002 clk  in  1  single clock; all logic is rising-edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 psel  in  1  APB select.
REQ-005 penable  in  1  APB access phase.
REQ-006 pwrite  in  1  APB direction; 1 = write.
REQ-007 paddr  in  6  APB byte address.
REQ-008 pwdata  in  32  APB write data.
REQ-009 pready  out  1  APB transfer complete; one-cycle registered pulse.
REQ-010 prdata  out  32  APB read data; valid only while pready=1.
REQ-011 pslverr  out  1  APB error; valid only while pready=1.
REQ-012 mbx_write  out  1  write strobe to the mailbox controller port; held until mbx_ready.
REQ-013 mbx_read  out  1  read strobe to the mailbox controller port; held until mbx_ready.
REQ-014 mbx_addr  out  6  registered word-aligned address to the mailbox controller.
REQ-015 mbx_wdata  out  32  registered write data to the mailbox controller.
REQ-016 mbx_ready  in  1  mailbox controller completion; stays high while the strobe is held.
REQ-017 mbx_rdata  in  32  mailbox controller read data; sampled when mbx_ready=1.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCESS, RECOVER.
REQ-019 IDLE, psel=1 & penable=1 & paddr[1:0]=0: capture paddr/pwdata into mbx_addr/mbx_wdata, assert mbx_write (pwrite=1) or mbx_read (pwrite=0) from the next cycle, clear the timeout counter, go to ACCESS.
REQ-020 IDLE, psel=1 & penable=1 & paddr[1:0]!=0: assert no strobe; next cycle pready=1, pslverr=1, prdata=0; go to RECOVER.
REQ-021 ACCESS, mbx_ready=1: deassert the strobe next cycle; next cycle pready=1, pslverr=0, prdata=mbx_rdata for reads and 0 for writes; go to RECOVER.
REQ-022 ACCESS, mbx_ready=0: increment the counter; when the counter reaches TIMEOUT_CYCLES-1, deassert the strobe; next cycle pready=1, pslverr=1, prdata=0; go to RECOVER.
REQ-023 If mbx_ready=1 in the same cycle the timeout is reached, the bridge SHALL take the success path (REQ-021).
REQ-024 RECOVER SHALL return to IDLE on the first cycle with mbx_ready=0. No new transfer SHALL be accepted before IDLE.
REQ-025 pready SHALL be high for exactly one cycle per accepted transfer. pready, prdata and pslverr SHALL be 0 in every other cycle.
REQ-026 mbx_write and mbx_read SHALL never be high in the same cycle. Strobe, address and data SHALL be stable throughout ACCESS.
REQ-027 If psel drops during ACCESS, the bridge SHALL still complete the downstream transfer per REQ-021/022 and issue its pready pulse.
REQ-028 Latency, fast register with no wait: access phase seen at cycle 0, strobe high in cycle 1, mbx_ready in cycle 2, pready in cycle 3.
REQ-029 The timeout counter SHALL be $clog2(TIMEOUT_CYCLES) bits wide and SHALL NOT wrap within a transfer.

Reset
REQ-030 resetn=0 SHALL asynchronously force state=IDLE, counter=0, and all outputs (pready, prdata, pslverr, mbx_write, mbx_read, mbx_addr, mbx_wdata) to 0.
REQ-031 A reset asserted mid-ACCESS SHALL drop the strobe immediately and SHALL produce no pready pulse for the aborted transfer.

Structure
REQ-032 The FSM state enum and the address-width (6) and data-width (32) constants SHALL reside in the shared package mailbox_pkg.
REQ-033 The block SHALL be a single module with no sub-modules. One instance SHALL be placed per mailbox controller side (A and B).

Verification
REQ-034 Read, addr 0x00, mbx_ready high 1 cycle after strobe, mbx_rdata=0x1 -> pready in cycle 3, prdata=0x00000001, pslverr=0.
REQ-035 Write, addr 0x30, data 0xDEADBEEF, mbx_ready after 5 cycles -> mbx_write held 5 cycles with mbx_wdata=0xDEADBEEF, then pready=1, pslverr=0.
REQ-036 Read, addr 0x10, mbx_ready never asserted, TIMEOUT_CYCLES=64 -> strobe dropped after 64 ACCESS cycles, pready=1, pslverr=1, prdata=0.
REQ-037 Read, addr 0x22 (misaligned) -> no mbx strobe, pready and pslverr high on the next cycle.
REQ-038 resetn low 2 cycles into ACCESS, then back-to-back writes -> strobes 0 immediately, no pready for the aborted transfer; each later write waits in RECOVER until mbx_ready=0 before being accepted.
REQ-039 mbx_ready rises in the same cycle the counter reaches TIMEOUT_CYCLES-1 -> pslverr=0, prdata=mbx_rdata.
